hazard_branch_controller: RTL and testbench
===========================================

// Module: hazard_branch_controller
// PURPOSE
//  Pipeline sequencing controller for the 5-stage MIPS datapath.
//  - Consumes the branch-condition terms from EX/MEM and detects load-use hazards in ID.
//  - Drives PC write-enable, IF/ID write-enable, per-stage flushes and the PC-source select.
//  - Keeps saturating stall/flush event counters for debug readout.
// PARAMETERS
//  STALL_CYCLES  1   bubbles inserted per load-use hazard (1..15)
//  CNT_W         16  width of each event counter
// PORTS
//  Clk            in   1      clock, rising edge
//  Rst            in   1      synchronous reset, active-low
//  IDEX_MemRead   in   1      instruction in EX is a load
//  IDEX_Rt        in   5      load destination register
//  IFID_Rs        in   5      ID-stage source register 1
//  IFID_Rt        in   5      ID-stage source register 2
//  IFID_UsesRt    in   1      ID instruction reads Rt
//  IFID_Jump      in   1      ID instruction is j/jal
//  EXMEM_Branch   in   1      beq in MEM
//  EXMEM_BranchNE in   1      bne in MEM
//  EXMEM_Zero     in   1      ALU zero flag in MEM
//  PCWrite        out  1      PC register enable
//  IFID_Write     out  1      IF/ID register enable
//  IFID_Flush     out  1      zero IF/ID on next edge
//  IDEX_Flush     out  1      zero ID/EX control on next edge
//  EXMEM_Flush    out  1      zero EX/MEM control on next edge
//  PCSrc          out  2      00 PC+4, 01 branch target, 10 jump target
//  StallCount     out  CNT_W  load-use stall cycles, saturating
//  FlushCount     out  CNT_W  taken-branch and jump redirects, saturating
// BEHAVIOUR
//  Reset: while Rst=0, sampled on Clk.
//   - State goes to RUN; counters clear.
//   - Outputs: PCWrite=0, IFID_Write=0, all three flushes=1, PCSrc=00.
//  Combinational terms:
//   - Taken = (EXMEM_Branch & EXMEM_Zero) | (EXMEM_BranchNE & ~EXMEM_Zero).
//   - Hazard = IDEX_MemRead & (IDEX_Rt!=0) & (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
//  States: RUN, STALL. Control outputs are combinational from state + inputs.
//  RUN:
//   - Taken: PCSrc=01; IFID_Flush, IDEX_Flush and EXMEM_Flush =1; PCWrite=1; FlushCount++.
//     Taken overrides Hazard and Jump (younger instructions are wrong-path). Stay in RUN.
//   - else Hazard: PCWrite=0, IFID_Write=0, IDEX_Flush=1, StallCount++.
//     If STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-2.
//   - else Jump: PCSrc=10, IFID_Flush=1, FlushCount++.
//   - else all enables 1, flushes 0, PCSrc=00.
//  STALL:
//   - Outputs as Hazard case; StallCount++.
//   - cnt==0 returns to RUN; otherwise cnt--.
//   - Taken in STALL: abort the stall, apply the Taken outputs, return to RUN, clear cnt.
//  Latency: zero-cycle decision; exactly STALL_CYCLES bubbles per load-use.
//  Counters saturate at all-ones. Counter increments use the same cycle's decision.
//  Reset mid-STALL: return to RUN; no residual stall after reset is released.
//  Hazard on IDEX_Rt=0 never stalls.
// STRUCTURE
//  Shared package pipe_ctrl_pkg:
//   - PCSrc encodings PCSRC_SEQ/PCSRC_BR/PCSRC_JMP.
//   - State typedef {RUN, STALL}.
//  Sub-module sat_counter #(W):
//   - Enable + synchronous active-low clear.
//   - Instantiated twice.
// TESTING
//  1. Rst=0 two cycles -> PCWrite=0, all flushes=1, counters=0.
//     Release -> PCWrite=1, PCSrc=00.
//  2. IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 -> one cycle PCWrite=0, IDEX_Flush=1.
//     StallCount=1, then normal flow.
//  3. STALL_CYCLES=3, same hazard -> exactly 3 stalled cycles.
//     Taken on stall cycle 2 -> flush and PCSrc=01, RUN next cycle.
//  4. EXMEM_BranchNE=1, Zero=0, with Hazard and Jump also set -> PCSrc=01.
//     Three flushes =1, no stall, FlushCount +1.
//  5. Load with IDEX_Rt=0 matching IFID_Rs=0 -> no stall.
//     IFID_Jump=1 -> PCSrc=10, IFID_Flush=1.
//  6. CNT_W=4, 20 hazards -> StallCount holds at 15.
//     Rst low mid-STALL -> state RUN, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/branch controller: PC source select and FSM states.
package pipe_ctrl_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   // Wide enough for the largest remaining-bubble count (STALL_CYCLES up to 15).
   localparam int STALL_CNT_W = 4;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on en, holds at all-ones, synchronous active-low clear.
// Latency: count reflects an enabled cycle one edge later; no backpressure.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_branch_controller.sv
// Pipeline sequencing for the 5-stage MIPS datapath: load-use stalls, branch/jump redirects, event counters.
// Latency: zero-cycle combinational decision; load-use holds PC and IF/ID for STALL_CYCLES cycles.
module hazard_branch_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             IFID_Jump,
   input  logic             EXMEM_Branch,
   input  logic             EXMEM_BranchNE,
   input  logic             EXMEM_Zero,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             EXMEM_Flush,
   output logic [1:0]       PCSrc,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // Bubbles still owed after the first one, loaded on entry to STALL.
   localparam logic [STALL_CNT_W-1:0] STALL_RELOAD =
      (STALL_CYCLES > 1) ? STALL_CNT_W'(STALL_CYCLES - 2) : '0;

   state_t                 state, state_nxt;
   logic [STALL_CNT_W-1:0] cnt, cnt_nxt;
   logic                   taken, hazard;
   logic                   stall_evt, flush_evt;

   assign taken  = (EXMEM_Branch & EXMEM_Zero) | (EXMEM_BranchNE & ~EXMEM_Zero);
   assign hazard = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      PCSrc       = PCSRC_SEQ;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;

      if (!Rst) begin
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         IFID_Flush  = 1'b1;
         IDEX_Flush  = 1'b1;
         EXMEM_Flush = 1'b1;
         state_nxt   = RUN;
         cnt_nxt     = '0;
      end else if (taken) begin
         // Everything younger than the branch is wrong-path, including a pending stall.
         PCSrc       = PCSRC_BR;
         IFID_Flush  = 1'b1;
         IDEX_Flush  = 1'b1;
         EXMEM_Flush = 1'b1;
         flush_evt   = 1'b1;
         state_nxt   = RUN;
         cnt_nxt     = '0;
      end else if ((state == STALL) || hazard) begin
         PCWrite    = 1'b0;
         IFID_Write = 1'b0;
         IDEX_Flush = 1'b1;
         stall_evt  = 1'b1;
         if (state == STALL) begin
            if (cnt == '0) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end else if (STALL_CYCLES > 1) begin
            state_nxt = STALL;
            cnt_nxt   = STALL_RELOAD;
         end
      end else if (IFID_Jump) begin
         PCSrc      = PCSRC_JMP;
         IFID_Flush = 1'b1;
         flush_evt  = 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (Clk),
      .clr_n (Rst),
      .en    (stall_evt),
      .count (StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (Clk),
      .clr_n (Rst),
      .en    (flush_evt),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_branch_controller.sv
// Drives three controller instances (1-cycle, 3-cycle, 4-bit counters) with shared stimulus
// and checks each against an independent cycle model through a scoreboard queue.
module tb_hazard_branch_controller;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       IDEX_MemRead;
   logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
   logic       IFID_UsesRt, IFID_Jump, EXMEM_Branch, EXMEM_BranchNE, EXMEM_Zero;

   logic       pcw[3], ifw[3], iff_o[3], ief[3], emf[3];
   logic [1:0] src[3];
   logic [15:0] sc0, sc1, fc0, fc1;
   logic [3:0]  sc2, fc2;

   always #5 Clk = ~Clk;

   hazard_branch_controller #(.STALL_CYCLES(1), .CNT_W(16)) u0 (
      .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs),
      .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .EXMEM_Branch(EXMEM_Branch),
      .EXMEM_BranchNE(EXMEM_BranchNE), .EXMEM_Zero(EXMEM_Zero), .PCWrite(pcw[0]), .IFID_Write(ifw[0]),
      .IFID_Flush(iff_o[0]), .IDEX_Flush(ief[0]), .EXMEM_Flush(emf[0]), .PCSrc(src[0]),
      .StallCount(sc0), .FlushCount(fc0));

   hazard_branch_controller #(.STALL_CYCLES(3), .CNT_W(16)) u1 (
      .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs),
      .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .EXMEM_Branch(EXMEM_Branch),
      .EXMEM_BranchNE(EXMEM_BranchNE), .EXMEM_Zero(EXMEM_Zero), .PCWrite(pcw[1]), .IFID_Write(ifw[1]),
      .IFID_Flush(iff_o[1]), .IDEX_Flush(ief[1]), .EXMEM_Flush(emf[1]), .PCSrc(src[1]),
      .StallCount(sc1), .FlushCount(fc1));

   hazard_branch_controller #(.STALL_CYCLES(1), .CNT_W(4)) u2 (
      .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs),
      .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt), .IFID_Jump(IFID_Jump), .EXMEM_Branch(EXMEM_Branch),
      .EXMEM_BranchNE(EXMEM_BranchNE), .EXMEM_Zero(EXMEM_Zero), .PCWrite(pcw[2]), .IFID_Write(ifw[2]),
      .IFID_Flush(iff_o[2]), .IDEX_Flush(ief[2]), .EXMEM_Flush(emf[2]), .PCSrc(src[2]),
      .StallCount(sc2), .FlushCount(fc2));

   typedef struct packed {
      logic [2:0][6:0]  ctrl;
      logic [2:0][15:0] sc;
      logic [2:0][15:0] fc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_bad = 0;

   // Model state per instance: in_stall, bubbles left after the current one, counters.
   bit   m_stall[3];
   int   m_left[3];
   int   m_sc[3];
   int   m_fc[3];

   function automatic int stall_cycles(input int i);
      return (i == 1) ? 3 : 1;
   endfunction

   function automatic int cnt_max(input int i);
      return (i == 2) ? 15 : 65535;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle of stimulus: drive, predict, compare mid-cycle, advance past the edge.
   task automatic cyc(input logic rst, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic ur, input logic jmp,
                      input logic br, input logic bne, input logic z);
      exp_t e;
      logic [6:0] c;
      logic taken, haz;
      Rst = rst; IDEX_MemRead = mr; IDEX_Rt = ert; IFID_Rs = rs; IFID_Rt = rt;
      IFID_UsesRt = ur; IFID_Jump = jmp; EXMEM_Branch = br; EXMEM_BranchNE = bne; EXMEM_Zero = z;
      taken = (br && z) || (bne && !z);
      haz   = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
      for (int i = 0; i < 3; i++) begin
         e.sc[i] = 16'(m_sc[i]);
         e.fc[i] = 16'(m_fc[i]);
         // ctrl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc}
         if (!rst) begin
            c = 7'b00_111_00;
            m_stall[i] = 0; m_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
         end else if (taken) begin
            c = 7'b11_111_01;
            m_stall[i] = 0; m_left[i] = 0;
            if (m_fc[i] < cnt_max(i)) m_fc[i]++;
         end else if (m_stall[i] || haz) begin
            c = 7'b00_010_00;
            if (m_sc[i] < cnt_max(i)) m_sc[i]++;
            if (m_stall[i]) begin
               if (m_left[i] == 0) m_stall[i] = 0;
               else m_left[i]--;
            end else if (stall_cycles(i) > 1) begin
               m_stall[i] = 1;
               m_left[i]  = stall_cycles(i) - 2;
            end
         end else if (jmp) begin
            c = 7'b11_100_10;
            if (m_fc[i] < cnt_max(i)) m_fc[i]++;
         end else begin
            c = 7'b11_000_00;
         end
         e.ctrl[i] = c;
      end
      sb.push_back(e);
      @(negedge Clk);
      e = sb.pop_front();
      for (int i = 0; i < 3; i++)
         check_val($sformatf("ctrl%0d", i), {25'd0, pcw[i], ifw[i], iff_o[i], ief[i], emf[i], src[i]},
                   {25'd0, e.ctrl[i]});
      check_val("stall0", {16'd0, sc0}, {16'd0, e.sc[0]});
      check_val("stall1", {16'd0, sc1}, {16'd0, e.sc[1]});
      check_val("stall2", {28'd0, sc2}, {16'd0, e.sc[2]});
      check_val("flush0", {16'd0, fc0}, {16'd0, e.fc[0]});
      check_val("flush1", {16'd0, fc1}, {16'd0, e.fc[1]});
      check_val("flush2", {28'd0, fc2}, {16'd0, e.fc[2]});
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1, 0, 5'd0, 5'd1, 5'd2, 1, 0, 0, 0, 0);
   endtask

   task automatic load_use(input logic [4:0] r);
      cyc(1, 1, r, r, 5'd3, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      Rst = 0; IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
      IFID_UsesRt = 0; IFID_Jump = 0; EXMEM_Branch = 0; EXMEM_BranchNE = 0; EXMEM_Zero = 0;
      @(posedge Clk); #1;

      // Reset held, then released.
      cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
      idle(2);

      // Load-use on Rs; the 3-cycle instance keeps stalling after the hazard clears.
      load_use(5'd8);
      idle(4);

      // Load-use through Rt, with and without UsesRt.
      cyc(1, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0, 0);
      idle(3);
      cyc(1, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0, 0);
      idle(1);

      // Taken beq during the second stall cycle aborts the stall.
      load_use(5'd8);
      cyc(1, 0, 5'd0, 5'd1, 5'd2, 1, 0, 1, 0, 1);
      idle(3);

      // bne taken overrides a simultaneous hazard and jump.
      cyc(1, 1, 5'd7, 5'd7, 5'd7, 1, 1, 0, 1, 0);
      idle(1);
      // Branch present but not taken: hazard wins.
      cyc(1, 1, 5'd7, 5'd7, 5'd7, 1, 1, 1, 0, 0);
      idle(3);

      // Load to $0 never stalls; jump alone redirects.
      cyc(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
      cyc(1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 0, 0);
      cyc(1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
      idle(1);

      // Twenty hazards: the 4-bit counter must pin at 15.
      for (int k = 0; k < 20; k++) begin
         load_use(5'(k % 31 + 1));
         idle(3);
      end

      // Reset during STALL: no residual bubbles afterwards.
      load_use(5'd12);
      cyc(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0, 0);
      idle(4);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
